stepper_sequencer: RTL

STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

---
 rtl/stepper_pkg.sv | 22 ++
 rtl/stepper_sequencer_edge_detect.sv | 20 ++
 rtl/stepper_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper sequencer.
// FSM encoding, coil phase table and direction codes.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Index 0 is the rightmost entry.
  localparam logic [7:0][3:0] PHASE_TBL = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  localparam logic [2:0] PHASE_RST = 3'd1;

endpackage

// File: rtl/stepper_sequencer_edge_detect.sv
// Rising-edge detector with a history register that resets to 1.
// Ports: clk, reset (sync, high), sig in, rise out (combinational).
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Reset to 1 so a level already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b1;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor move sequencer: takes move commands, steps coils on clk_div.
// Ports: clk/reset, clk_div, enable, cmd_* handshake, abort, coil, status.
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit HALF_STEP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_div,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic [CNT_W-1:0] position
);

  localparam logic [2:0] PH_INC = HALF_STEP ? 3'd1 : 3'd2;

  state_t     state;
  logic       dir;
  logic [2:0] phase;
  logic [2:0] phase_nxt;
  logic       tick;
  logic       step;

  edge_detect u_tick (
    .clk   (clk),
    .reset (reset),
    .sig   (clk_div),
    .rise  (tick)
  );

  // Abort takes priority over a coincident tick.
  assign step = (state == ST_RUN) & enable & tick & ~abort;

  always_comb begin
    phase_nxt = phase;
    if (step) begin
      if (dir == DIR_FWD) phase_nxt = phase + PH_INC;
      else                phase_nxt = phase - PH_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dir        <= DIR_FWD;
      phase      <= PHASE_RST;
      coil       <= 4'b0000;
      steps_left <= '0;
      position   <= '0;
    end else begin
      phase <= phase_nxt;
      coil  <= enable ? PHASE_TBL[phase_nxt] : 4'b0000;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            steps_left <= cmd_steps;
            dir        <= cmd_dir;
            state      <= (cmd_steps == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_DONE;
          end else if (step) begin
            steps_left <= steps_left - CNT_W'(1);
            if (dir == DIR_FWD) position <= position + CNT_W'(1);
            else                position <= position - CNT_W'(1);
            if (steps_left == CNT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);

endmodule
